// File: rtl/ad_in_capture.sv
// ad_in_capture: dual offset-binary ADC capture with settle gating and block averaging.
// Define ADC_OVR_EN to enable sticky per-channel overrange flags.
module ad_in_capture #(
  parameter int Ndata      = 12,
  parameter int SETTLE     = 16,
  parameter int DECIM_LOG2 = 0
) (
  input  logic             dac_clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [Ndata-1:0] in_ad0_data,
  input  logic [Ndata-1:0] in_ad1_data,
  input  logic             in_ad0_otr,
  input  logic             in_ad1_otr,
  input  logic             ovr_clr,
  output logic             out_ad_clk,
  output logic [Ndata-1:0] out_ad0_data,
  output logic [Ndata-1:0] out_ad1_data,
  output logic             out_valid,
  output logic [1:0]       out_ovr
);
  localparam int AW = Ndata + DECIM_LOG2;
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam int PW = DECIM_LOG2 > 0 ? DECIM_LOG2 : 1;
  localparam int PHASE_MAX = (1 << DECIM_LOG2) - 1;
  typedef enum logic [1:0] {IDLE, SETT, RUN} state_t;
  state_t state, state_nx;
  logic [SW-1:0] settle_cnt;
  logic [PW-1:0] phase;
  logic [Ndata-1:0] s1_d0, s1_d1;
  logic signed [Ndata-1:0] s2_d0, s2_d1;
  logic signed [AW-1:0] acc0, acc1, sum0, sum1;
  logic run, last;
  assign out_ad_clk = ~dac_clk;
  always_comb begin
    state_nx = !en ? IDLE :
               state == IDLE ? SETT :
               (state == SETT && settle_cnt == SW'(SETTLE - 1)) ? RUN : state;
  end
  assign run  = state == RUN && en;
  assign last = phase == PW'(PHASE_MAX);
  assign sum0 = acc0 + AW'(s2_d0);
  assign sum1 = acc1 + AW'(s2_d1);
  always_ff @(posedge dac_clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      s1_d0        <= '0;
      s1_d1        <= '0;
      s2_d0        <= '0;
      s2_d1        <= '0;
      acc0         <= '0;
      acc1         <= '0;
      phase        <= '0;
      out_ad0_data <= '0;
      out_ad1_data <= '0;
      out_valid    <= 1'b0;
    end else begin
      state      <= state_nx;
      settle_cnt <= state == SETT ? settle_cnt + 1'b1 : '0;
      s1_d0      <= in_ad0_data;
      s1_d1      <= in_ad1_data;
      s2_d0      <= {~s1_d0[Ndata-1], s1_d0[Ndata-2:0]};
      s2_d1      <= {~s1_d1[Ndata-1], s1_d1[Ndata-2:0]};
      // Window closes on the last phase; a dropped enable discards the partial sum.
      if (run && last) begin
        out_ad0_data <= Ndata'(sum0 >>> DECIM_LOG2);
        out_ad1_data <= Ndata'(sum1 >>> DECIM_LOG2);
        out_valid    <= 1'b1;
        acc0         <= '0;
        acc1         <= '0;
        phase        <= '0;
      end else if (run) begin
        out_valid <= 1'b0;
        acc0      <= sum0;
        acc1      <= sum1;
        phase     <= phase + 1'b1;
      end else begin
        out_valid <= 1'b0;
        acc0      <= '0;
        acc1      <= '0;
        phase     <= '0;
      end
    end
  end
`ifdef ADC_OVR_EN
  logic [1:0] s1_otr, s2_otr, ovr;
  always_ff @(posedge dac_clk) begin
    if (!reset_n) begin
      s1_otr <= '0;
      s2_otr <= '0;
      ovr    <= '0;
    end else begin
      s1_otr <= {in_ad1_otr, in_ad0_otr};
      s2_otr <= s1_otr;
      ovr    <= (ovr & {2{~ovr_clr}}) | (state == RUN ? s2_otr : 2'b00);
    end
  end
  assign out_ovr = ovr;
`else
  logic unused_ovr;
  assign unused_ovr = &{1'b0, in_ad0_otr, in_ad1_otr, ovr_clr};
  assign out_ovr    = 2'b00;
`endif
endmodule

// File: tb/tb_ad_in_capture.sv
// tb_ad_in_capture: directed checks of settle, conversion, averaging, overrange and reset.
module tb_ad_in_capture;
  logic dac_clk = 1'b0, reset_n = 1'b0, en_a = 1'b0, en_b = 1'b0;
  logic ovr_clr = 1'b0, otr0 = 1'b0, otr1 = 1'b0;
  logic [11:0] a0 = '0, a1 = '0, b0 = 12'h800, b1 = 12'h800;
  logic [11:0] qa0, qa1, qb0, qb1;
  logic clk_a, clk_b, va, vb;
  logic [1:0] ovr_a, ovr_b;
  int n_cmp = 0, n_bad = 0, n, cnt;
  always #5 dac_clk = ~dac_clk;
  ad_in_capture #(.Ndata(12), .SETTLE(16), .DECIM_LOG2(0)) u_a (
    .dac_clk(dac_clk), .reset_n(reset_n), .en(en_a), .in_ad0_data(a0), .in_ad1_data(a1),
    .in_ad0_otr(otr0), .in_ad1_otr(otr1), .ovr_clr(ovr_clr), .out_ad_clk(clk_a),
    .out_ad0_data(qa0), .out_ad1_data(qa1), .out_valid(va), .out_ovr(ovr_a));
  ad_in_capture #(.Ndata(12), .SETTLE(16), .DECIM_LOG2(2)) u_b (
    .dac_clk(dac_clk), .reset_n(reset_n), .en(en_b), .in_ad0_data(b0), .in_ad1_data(b1),
    .in_ad0_otr(1'b0), .in_ad1_otr(1'b0), .ovr_clr(1'b0), .out_ad_clk(clk_b),
    .out_ad0_data(qb0), .out_ad1_data(qb1), .out_valid(vb), .out_ovr(ovr_b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge dac_clk);
    #1;
  endtask
  task automatic wait_v(input bit sel, inout int k);
    while (!(sel ? vb : va) && k < 100) begin
      tick;
      k++;
    end
  endtask
  function automatic logic [11:0] pin0(input int i);
    return i == 16 ? 12'h801 : i == 17 ? 12'h803 : i == 18 ? 12'h805 : i == 19 ? 12'h807 :
           i >= 20 ? 12'h80C : 12'h800;
  endfunction
  function automatic logic [11:0] pin1(input int i);
    return (i >= 16 && i <= 18) ? 12'h7FF : i == 19 ? 12'h7FE : i >= 20 ? 12'h7FC : 12'h800;
  endfunction
  initial begin
    a0 = 12'h5A5;
    a1 = 12'h3C3;
    tick;
    tick;
    chk("rst_a0", qa0, 0);
    chk("rst_a1", qa1, 0);
    chk("rst_va", va, 0);
    chk("rst_ovr", ovr_a, 0);
    chk("rst_b0", qb0, 0);
    chk("rst_vb", vb, 0);
    chk("ad_clk", clk_a, 0);
    // D=0: 16 settle cycles, then a strobe every cycle
    reset_n = 1'b1;
    en_a = 1'b1;
    a0 = 12'h000;
    a1 = 12'hFFF;
    n = 0;
    wait_v(0, n);
    chk("settle_a", n, 18);
    chk("first_a0", qa0, 12'h800);
    a0 = 12'h800;
    a1 = 12'h7FF;
    tick;
    tick;
    chk("lat_hold", qa0, 12'h800);
    tick;
    chk("conv_800", qa0, 12'h000);
    chk("conv_ch1", qa1, 12'hFFF);
    a0 = 12'hFFF;
    tick;
    tick;
    chk("lat_hold2", qa0, 12'h000);
    tick;
    chk("conv_fff", qa0, 12'h7FF);
    a0 = 12'h000;
    tick;
    tick;
    tick;
    chk("conv_000", qa0, 12'h800);
    chk("valid_run", va, 1);
`ifdef ADC_OVR_EN
    otr0 = 1'b1;
    tick;
    otr0 = 1'b0;
    tick;
    tick;
    chk("ovr_set", ovr_a, 2'b01);
    tick;
    tick;
    chk("ovr_sticky", ovr_a, 2'b01);
    otr1 = 1'b1;
    tick;
    otr1 = 1'b0;
    tick;
    ovr_clr = 1'b1;
    tick;
    ovr_clr = 1'b0;
    chk("ovr_setwins", ovr_a, 2'b10);
    tick;
    ovr_clr = 1'b1;
    tick;
    ovr_clr = 1'b0;
    chk("ovr_clr", ovr_a, 2'b00);
`else
    otr0 = 1'b1;
    otr1 = 1'b1;
    repeat (4) tick;
    otr0 = 1'b0;
    otr1 = 1'b0;
    chk("ovr_off", ovr_a, 2'b00);
`endif
    // D=2 averaging on the second instance
    en_b = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 21; i++) begin
      b0 = pin0(i);
      b1 = pin1(i);
      tick;
      if (i <= 20 && vb) cnt++;
    end
    chk("no_early_vb", cnt, 0);
    chk("win1_valid", vb, 1);
    chk("win1_avg0", qb0, 12'h004);
    chk("win1_floor1", qb1, 12'hFFE);
    repeat (3) tick;
    chk("hold_vb", vb, 0);
    chk("hold_b0", qb0, 12'h004);
    tick;
    chk("win2_valid", vb, 1);
    chk("win2_b0", qb0, 12'h00C);
    chk("win2_b1", qb1, 12'hFFC);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (vb) cnt++;
    end
    chk("strobe_rate", cnt, 2);
    // drop enable after two samples of a window
    tick;
    tick;
    en_b = 1'b0;
    tick;
    chk("drop_vb", vb, 0);
    chk("drop_hold", qb0, 12'h00C);
    tick;
    chk("idle_vb", vb, 0);
    en_b = 1'b1;
    n = 0;
    wait_v(1, n);
    chk("resettle_b", n, 21);
    chk("fresh_window", qb0, 12'h00C);
    // reset mid-window
    tick;
    reset_n = 1'b0;
    tick;
    chk("mid_rst_a0", qa0, 0);
    chk("mid_rst_va", va, 0);
    chk("mid_rst_b0", qb0, 0);
    chk("mid_rst_b1", qb1, 0);
    chk("mid_rst_vb", vb, 0);
    chk("mid_rst_ovr", ovr_a, 0);
    reset_n = 1'b1;
    n = 0;
    wait_v(0, n);
    chk("post_rst_a", n, 18);
    wait_v(1, n);
    chk("post_rst_b", n, 21);
    chk("post_rst_b0", qb0, 12'h00C);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
